// File: rtl/acc_output.sv
// acc_output: collects ACC_WIDTH streaming Q8.8 beats into a registered batch, with optional saturating accumulate
module acc_output #(
    parameter int ACC_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              acc_clear_i,
    input  logic                              acc_accum_i,
    input  logic                              acc_valid_i,
    input  logic [15:0]                       acc_data_in,
    input  logic                              acc_drain_i,
    output logic [0:ACC_WIDTH-1][15:0]        acc_data_out,
    output logic                              acc_batch_valid_o,
    output logic                              acc_busy_o,
    output logic                              acc_sat_o,
    output logic                              acc_err_o
);
    localparam int IW = $clog2(ACC_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t                       r_state, w_nstate;
    logic [IW-1:0]                r_idx, w_nidx, w_widx;
    logic [0:ACC_WIDTH-1][15:0]   r_buf;
    logic                         r_sat, r_err;
    logic                         w_accept, w_drop, w_ovf;
    logic [15:0]                  w_cur, w_wdata;
    logic [16:0]                  w_sum;

    // A beat in FULL is only taken when the batch is drained in the same cycle; it then starts at index 0.
    assign w_accept = acc_valid_i && (r_state != FULL || acc_drain_i);
    assign w_drop   = acc_valid_i && r_state == FULL && !acc_drain_i;
    assign w_widx   = (r_state == FULL) ? '0 : r_idx;

    // Select the entry being written so it can be accumulated onto.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < ACC_WIDTH; i++)
            if (w_widx == IW'(i)) w_cur = r_buf[i];
    end

    assign w_sum   = {w_cur[15], w_cur} + {acc_data_in[15], acc_data_in};
    assign w_ovf   = w_sum[16] ^ w_sum[15];
    assign w_wdata = !acc_accum_i ? acc_data_in : w_ovf ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];

    // Next-state and next-index logic; clear dominates every other input.
    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        if (acc_clear_i) begin
            w_nstate = IDLE;
            w_nidx   = '0;
        end else if (w_accept) begin
            w_nstate = (w_widx == IW'(ACC_WIDTH - 1)) ? FULL : FILL;
            w_nidx   = w_widx + 1'b1;
        end else if (r_state == FULL && acc_drain_i) begin
            w_nstate = IDLE;
            w_nidx   = '0;
        end
    end

    // State and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
        end
    end

    // Batch buffer and sticky saturation/drop flags.
    always_ff @(posedge clk) begin
        if (rst || acc_clear_i) begin
            r_buf <= '0;
            r_sat <= 1'b0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < ACC_WIDTH; i++)
                if (w_accept && w_widx == IW'(i)) r_buf[i] <= w_wdata;
            if (w_accept && acc_accum_i && w_ovf) r_sat <= 1'b1;
            if (w_drop) r_err <= 1'b1;
        end
    end

    assign acc_data_out      = r_buf;
    assign acc_batch_valid_o = (r_state == FULL);
    assign acc_busy_o        = (r_state == FILL);
    assign acc_sat_o         = r_sat;
    assign acc_err_o         = r_err;
endmodule

// File: doc/acc_output.md
ACC_OUTPUT -- requirements
Module: acc_output

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 2, meaning batch length in beats (legal range >= 1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port acc_clear_i  input  1  synchronous abort: empties buffer and returns to IDLE.
REQ-005 SHALL have port acc_accum_i  input  1  per-beat mode: 0 overwrites the buffer entry, 1 adds to it.
REQ-006 SHALL have port acc_valid_i  input  1  streaming beat qualifier from the upstream acc_input stage.
REQ-007 SHALL have port acc_data_in  input  16  streaming beat, signed two's complement Q8.8.
REQ-008 SHALL have port acc_drain_i  input  1  downstream acknowledge of a presented batch.
REQ-009 SHALL have port acc_data_out  output  16 x [0:ACC_WIDTH-1]  collected batch, registered.
REQ-010 SHALL have port acc_batch_valid_o  output  1  high while a complete batch is presented.
REQ-011 SHALL have port acc_busy_o  output  1  high in FILL (partial batch held).
REQ-012 SHALL have port acc_sat_o  output  1  sticky: a saturating add clamped.
REQ-013 SHALL have port acc_err_o  output  1  sticky: a beat was dropped.

Function
REQ-014 SHALL implement states IDLE, FILL, FULL and a beat index counter idx of width clog2(ACC_WIDTH)+1.
REQ-015 SHALL, in IDLE or FILL with acc_valid_i=1, write entry idx and set idx to idx+1.
REQ-016 SHALL write acc_data_in to the entry when acc_accum_i=0.
REQ-017 SHALL, when acc_accum_i=1, write the signed 16-bit saturating sum of entry and acc_data_in.
REQ-018 SHALL clamp positive overflow to 0x7FFF and negative overflow to 0x8000, then set acc_sat_o.
REQ-019 SHALL transition IDLE->FILL on an accepted beat when ACC_WIDTH>1.
REQ-020 SHALL transition to FULL on the beat that fills index ACC_WIDTH-1, including IDLE->FULL when ACC_WIDTH=1.
REQ-021 SHALL make a beat accepted in cycle N visible on acc_data_out in cycle N+1.
REQ-022 SHALL assert acc_batch_valid_o in cycle N+1 when the last beat is accepted in cycle N.
REQ-023 SHALL hold idx, state and buffer unchanged through acc_valid_i gaps in FILL, with no timeout.
REQ-024 SHALL hold acc_data_out and acc_batch_valid_o stable in FULL until acc_drain_i=1.
REQ-025 SHALL, in FULL with acc_drain_i=1 and acc_valid_i=0, go to IDLE with idx=0 and retain buffer contents.
REQ-026 SHALL, in FULL with acc_drain_i=1 and acc_valid_i=1, accept that beat as index 0 of the next batch and go to FILL (or FULL when ACC_WIDTH=1).
REQ-027 SHALL, in FULL with acc_drain_i=0 and acc_valid_i=1, drop the beat, leave the buffer unchanged and set acc_err_o.
REQ-028 SHALL ignore acc_drain_i outside FULL.
REQ-029 SHALL give acc_clear_i priority over all inputs except rst.
REQ-030 SHALL, on acc_clear_i, zero the buffer, set idx=0, state=IDLE, and clear acc_sat_o and acc_err_o.
REQ-031 SHALL clear acc_sat_o and acc_err_o only through rst or acc_clear_i.
REQ-032 SHALL drive acc_busy_o as 1 exactly in FILL and acc_batch_valid_o as 1 exactly in FULL.

Reset
REQ-033 SHALL, on rst, set state=IDLE, idx=0, all acc_data_out entries=0x0000, and acc_batch_valid_o, acc_busy_o, acc_sat_o, acc_err_o all 0.
REQ-034 SHALL let rst mid-FILL or in FULL discard the partial or presented batch with no output pulse.

Verification (ACC_WIDTH=2)
REQ-035 SHALL cover: overwrite beats 0x0100, 0x0280 in consecutive cycles -> batch_valid one cycle after the second beat, data_out={0x0100,0x0280}.
REQ-036 SHALL cover: accumulate batch {0x7000,0x8100} onto {0x2000,0x8100} -> data_out={0x7FFF,0x8000}, acc_sat_o=1.
REQ-037 SHALL cover: beat, 3 idle cycles, beat -> busy high during the gap, batch_valid after the second beat.
REQ-038 SHALL cover: FULL, valid without drain -> beat dropped, acc_err_o=1, data_out unchanged.
REQ-039 SHALL cover: drain and beat 0x0040 in the same cycle -> next cycle state=FILL, entry0=0x0040, batch_valid=0.
REQ-040 SHALL cover: rst and clear asserted mid-FILL -> all outputs return to their reset values the next cycle.
